// File: rtl/serial_addsub_nbit_if.sv
// Handshake and data bundle for the serial add/subtract unit.
// The master side is the producer/consumer pair; the slave side is the arithmetic block.
interface serial_addsub_nbit_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         sub_en;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, x, y, sub_en, out_ready,
    input  in_ready, out_valid, s, c_out, overflow, busy
  );

  modport slave (
    input  in_valid, x, y, sub_en, out_ready,
    output in_ready, out_valid, s, c_out, overflow, busy
  );
endinterface

// File: rtl/serial_addsub_nbit.sv
// Multi-cycle N-bit two's-complement adder/subtractor working D bits per clock, LSB chunk first.
// Subtraction is done as x + ~y + 1: y is inverted at capture and the initial carry is sub_en.
module serial_addsub_nbit #(
  parameter int unsigned N = 8,
  parameter int unsigned D = 2
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_nbit_if.slave bus
);

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_err
    $error("serial_addsub_nbit: N must be >= 2 and a multiple of D, with 1 <= D <= N");
  end

  localparam int unsigned Chunks  = N / D;
  localparam int unsigned CntW    = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  logic [N-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [D-1:0]    x_chunk, y_chunk, sum_chunk;
  logic            carry_chunk;
  logic            msb_carry_in;

  // One D-bit slice of the ripple adder, selected by the chunk counter.
  always_comb begin
    x_chunk = x_q[cnt_q*D +: D];
    y_chunk = y_q[cnt_q*D +: D];
    {carry_chunk, sum_chunk} = {1'b0, x_chunk} + {1'b0, y_chunk} + {{D{1'b0}}, carry_q};
    // Carry into bit N-1 recovered from the full-adder relation on the top bit.
    msb_carry_in = x_q[N-1] ^ y_q[N-1] ^ sum_chunk[D-1];
  end

  // Next-state and datapath updates for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d     = bus.x;
          y_d     = bus.y ^ {N{bus.sub_en}};
          carry_d = bus.sub_en;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        s_d[cnt_q*D +: D] = sum_chunk;
        carry_d           = carry_chunk;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          c_out_d = carry_chunk;
          ovf_d   = msb_carry_in ^ carry_chunk;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;

endmodule
